hpdcache_mem_req_read_throttle: RTL and testbench
=================================================

HPDCACHE_MEM_REQ_READ_THROTTLE -- requirements
Module: hpdcache_mem_req_read_throttle

Placement: directly downstream of the memory read-request arbiter. Buffers the arbitrated read requests and caps in-flight reads to memory.

Interface
Parameters:
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8: maximum in-flight read transactions; >= 1.
REQ-003 SHALL have parameter hpdcache_mem_req_t, default logic: request payload type.

Ports:
REQ-004 SHALL provide clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL provide rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL provide req_valid_i  in  1  arbitrated request valid.
REQ-007 SHALL provide req_ready_o  out  1  FIFO can accept a request.
REQ-008 SHALL provide req_i  in  $bits(hpdcache_mem_req_t)  request payload.
REQ-009 SHALL provide mem_req_valid_o  out  1  request to memory valid.
REQ-010 SHALL provide mem_req_ready_i  in  1  memory accepts the request.
REQ-011 SHALL provide mem_req_o  out  $bits(hpdcache_mem_req_t)  request to memory (FIFO head).
REQ-012 SHALL provide resp_done_i  in  1  one-cycle pulse per completed read (last response beat handshaked).
REQ-013 SHALL provide fifo_count_o  out  $clog2(DEPTH+1)  occupied FIFO entries.
REQ-014 SHALL provide outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight reads.
REQ-015 SHALL provide idle_o  out  1  FIFO empty and outstanding_o == 0.
REQ-016 SHALL provide err_o  out  1  sticky: resp_done_i received with outstanding_o == 0.

Function
REQ-017 SHALL push on req_valid_i & req_ready_o and pop on mem_req_valid_o & mem_req_ready_i, preserving strict FIFO order.
REQ-018 SHALL drive req_ready_o = (fifo_count_o < DEPTH) from registered state only. When full, no push is accepted, even if a pop occurs in the same cycle.
REQ-019 SHALL allow a simultaneous push and pop when not full. Count is unchanged. The pushed entry is visible at the head no earlier than the next cycle.
REQ-020 SHALL drive mem_req_valid_o = (fifo_count_o != 0) & (outstanding_o < MAX_OUTSTANDING). There is no combinational path from req_valid_i or mem_req_ready_i to either valid or ready.
REQ-021 SHALL keep mem_req_o and mem_req_valid_o stable while mem_req_valid_o & !mem_req_ready_i. Stability holds by construction, because outstanding_o only increments on a handshake.
REQ-022 SHALL use read/write pointers of width log2(DEPTH) that wrap from DEPTH-1 to 0.
REQ-023 SHALL update outstanding_o as follows:
- +1 on memory handshake only;
- -1 on resp_done_i only;
- unchanged when both occur in the same cycle.
REQ-024 SHALL hold outstanding_o at 0 when resp_done_i arrives with outstanding_o == 0, and set err_o, unless a handshake occurs in the same cycle. In that case the rule of REQ-023 applies and err_o is not set.
REQ-025 SHALL never let outstanding_o exceed MAX_OUTSTANDING. When outstanding_o == MAX_OUTSTANDING, a resp_done_i lowers the count and mem_req_valid_o may rise the next cycle.
REQ-026 SHALL drive mem_req_o from the head entry as a registered-array read with no added latency. A request pushed into an empty FIFO appears on mem_req_valid_o one cycle after the push.

Reset
REQ-027 SHALL, with rst_i high at a clock edge, clear both pointers, fifo_count_o, outstanding_o and err_o.
REQ-028 SHALL produce the following outputs during and after reset: req_ready_o = 1, mem_req_valid_o = 0, idle_o = 1. mem_req_o is don't-care.
REQ-029 SHALL discard FIFO contents and in-flight accounting on reset mid-operation. Events in the reset cycle (push, pop, resp_done_i) are ignored.
REQ-030 SHALL not require the payload storage array to be reset.

Verification
REQ-031 Fill with DEPTH=4, mem_req_ready_i=0: push A,B,C,D in 4 cycles -> fifo_count_o=4, req_ready_o=0 on cycle 5, and a 5th request E is not accepted.
REQ-032 Ordering and latency: push A at cycle 0 with mem_req_ready_i=1 -> mem_req_valid_o=1 with payload A at cycle 1, and outstanding_o=1 at cycle 2.
REQ-033 Throttle with MAX_OUTSTANDING=2: 3 queued requests, memory always ready, no resp_done_i -> exactly 2 handshakes, then mem_req_valid_o=0 with outstanding_o=2. A single resp_done_i pulse -> third request issued the next cycle.
REQ-034 Simultaneous events: handshake and resp_done_i in the same cycle at outstanding_o=1 -> outstanding_o stays 1. resp_done_i at 0 with no handshake -> err_o=1, remaining set until reset.
REQ-035 Reset mid-operation: count=3, outstanding=2, assert rst_i one cycle -> next cycle fifo_count_o=0, outstanding_o=0, idle_o=1, err_o=0, mem_req_valid_o=0.
REQ-036 Random stress: random valid/ready/resp_done_i, with a scoreboard checking order and the invariants fifo_count_o <= DEPTH and outstanding_o <= MAX_OUTSTANDING, and that payload stays stable under backpressure.

Source files
------------

// File: rtl/hpdcache_mem_req_read_throttle.sv
`default_nettype none
// ============================================================================
//  Module      : hpdcache_mem_req_read_throttle
//  Description : Read-request FIFO placed after the memory read arbiter that
//                caps the number of in-flight reads issued to memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpdcache_mem_req_read_throttle #(
    parameter int  DEPTH           = 4,
    parameter int  MAX_OUTSTANDING = 8,
    parameter type hpdcache_mem_req_t = logic
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  hpdcache_mem_req_t                     req_i,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output hpdcache_mem_req_t                     mem_req_o,
    input  logic                                  resp_done_i,
    output logic [$clog2(DEPTH+1)-1:0]            fifo_count_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  idle_o,
    output logic                                  err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);

    hpdcache_mem_req_t  mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [OUT_W-1:0]   out_q,    out_d;
    logic               err_q,    err_d;

    logic               push;
    logic               pop;

    // Handshake qualifiers depend only on registered state, never on the
    // incoming valid/ready, so there is no combinational feed-through.
    assign req_ready_o     = (cnt_q < DEPTH_C);
    assign mem_req_valid_o = (cnt_q != '0) && (out_q < MAX_OUT_C);
    assign mem_req_o       = mem_q[rd_ptr_q];

    assign push = req_valid_i & req_ready_o;
    assign pop  = mem_req_valid_o & mem_req_ready_i;

    assign fifo_count_o  = cnt_q;
    assign outstanding_o = out_q;
    assign idle_o        = (cnt_q == '0) && (out_q == '0);
    assign err_o         = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        err_d    = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // A completion with nothing in flight is a protocol error; the
        // counter saturates at zero instead of wrapping.
        case ({pop, resp_done_i})
            2'b10: out_d = out_q + OUT_W'(1);
            2'b01: begin
                if (out_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    out_d = out_q - OUT_W'(1);
                end
            end
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // Payload storage carries no reset; stale entries are unreachable once
    // the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_mem_req_read_throttle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpdcache_mem_req_read_throttle
//  Description : Self-checking bench with a queue-based reference model,
//                directed scenarios and randomized stress.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdcache_mem_req_read_throttle;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    typedef logic [7:0] req_t;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    req_t       req_data;
    logic       mem_valid;
    logic       mem_ready;
    req_t       mem_data;
    logic       resp_done;
    logic [2:0] fifo_count;
    logic [1:0] outstanding;
    logic       idle;
    logic       err;

    hpdcache_mem_req_read_throttle #(
        .DEPTH              (DEPTH),
        .MAX_OUTSTANDING    (MAX_OUT),
        .hpdcache_mem_req_t (req_t)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_i           (req_data),
        .mem_req_valid_o (mem_valid),
        .mem_req_ready_i (mem_ready),
        .mem_req_o       (mem_data),
        .resp_done_i     (resp_done),
        .fifo_count_o    (fifo_count),
        .outstanding_o   (outstanding),
        .idle_o          (idle),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: request queue, in-flight count, sticky error flag.
    req_t m_q[$];
    int   m_out    = 0;
    bit   m_err    = 1'b0;
    bit   m_synced = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare DUT against model, advance model.
    task automatic cycle(input logic rv, input req_t d, input logic mr,
                         input logic rd, input logic rs);
        bit exp_ready;
        bit exp_valid;
        bit do_push;
        bit do_pop;
        req_valid = rv;
        req_data  = d;
        mem_ready = mr;
        resp_done = rd;
        rst       = rs;
        #1;
        if (m_synced) begin
            exp_ready = (m_q.size() < DEPTH);
            exp_valid = (m_q.size() != 0) && (m_out < MAX_OUT);
            check("ready", 32'(req_ready), 32'(exp_ready));
            check("valid", 32'(mem_valid), 32'(exp_valid));
            check("count", 32'(fifo_count), 32'(m_q.size()));
            check("outst", 32'(outstanding), 32'(m_out));
            check("idle",  32'(idle), 32'((m_q.size() == 0) && (m_out == 0)));
            check("err",   32'(err), 32'(m_err));
            if (exp_valid) check("head", 32'(mem_data), 32'(m_q[0]));
            if (!rs) begin
                do_push = rv && exp_ready;
                do_pop  = mr && exp_valid;
                if (do_pop)  void'(m_q.pop_front());
                if (do_push) m_q.push_back(d);
                if (rd && !do_pop && m_out == 0) m_err = 1'b1;
                else m_out = m_out + int'(do_pop) - int'(rd);
            end
        end
        if (rs) begin
            m_q.delete();
            m_out    = 0;
            m_err    = 1'b0;
            m_synced = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic mr);
        cycle(1'b0, 8'h00, mr, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        req_valid = 1'b0;
        req_data  = '0;
        mem_ready = 1'b0;
        resp_done = 1'b0;
        rst       = 1'b1;

        // Reset state
        do_reset();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_idle",  32'(idle), 32'd1);

        // Fill: four pushes with memory stalled, fifth rejected
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hD4, 1'b0, 1'b0, 1'b0);
        check("fill_cnt",   32'(fifo_count), 32'd4);
        check("fill_ready", 32'(req_ready), 32'd0);
        check("fill_head",  32'(mem_data), 32'hA1);
        cycle(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0);
        check("fill_noE",   32'(fifo_count), 32'd4);
        // Drain in order; E must never appear
        for (int i = 0; i < 6; i++) idle_cycle(1'b1);
        check("fill_drain", 32'(fifo_count), 32'd2);

        // Latency: push at cycle 0 visible at cycle 1, counted at cycle 2
        do_reset();
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        check("lat_valid", 32'(mem_valid), 32'd1);
        check("lat_data",  32'(mem_data), 32'h5A);
        check("lat_out1",  32'(outstanding), 32'd0);
        idle_cycle(1'b1);
        check("lat_out2",  32'(outstanding), 32'd1);

        // Throttle at MAX_OUT = 2
        do_reset();
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);
        check("thr_out",   32'(outstanding), 32'd2);
        check("thr_valid", 32'(mem_valid), 32'd0);
        check("thr_cnt",   32'(fifo_count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("thr_rel_v", 32'(mem_valid), 32'd1);
        check("thr_rel_d", 32'(mem_data), 32'h33);
        idle_cycle(1'b1);
        check("thr_out2",  32'(outstanding), 32'd2);

        // Simultaneous handshake and completion at outstanding 1
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        check("sim_pre",   32'(outstanding), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("sim_out",   32'(outstanding), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("err_set",   32'(err), 32'd1);
        check("err_out0",  32'(outstanding), 32'd0);
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
        check("err_stick", 32'(err), 32'd1);

        // Completion at zero coinciding with a handshake is not an error
        do_reset();
        cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("noerr_err", 32'(err), 32'd0);
        check("noerr_out", 32'(outstanding), 32'd0);

        // Reset mid-operation with count 3, outstanding 2
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, req_t'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
        check("mid_cnt",   32'(fifo_count), 32'd3);
        check("mid_out",   32'(outstanding), 32'd2);
        cycle(1'b1, 8'h82, 1'b1, 1'b1, 1'b1);
        check("mrst_cnt",  32'(fifo_count), 32'd0);
        check("mrst_out",  32'(outstanding), 32'd0);
        check("mrst_idle", 32'(idle), 32'd1);
        check("mrst_err",  32'(err), 32'd0);
        check("mrst_vld",  32'(mem_valid), 32'd0);

        // Random stress against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  req_t'($urandom),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 299) == 0));
            check("inv_cnt", 32'(fifo_count <= 3'(DEPTH)), 32'd1);
            check("inv_out", 32'(outstanding <= 2'(MAX_OUT)), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
